// File: rtl/frame_pkg.sv
// Shared types and constants for the frame dispatcher.
// RGB_DITHER_EN (macro) selects 2x2 Bayer dithering in the quantiser.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE,
    DONE
  } dispatch_state_t;

  localparam int FB_DATA_W = 12;

  // Indexed as BAYER2X2[y[0]][x[0]]: rows {0,8} and {12,4}.
  localparam logic [1:0][1:0][3:0] BAYER2X2 =
    {4'd4, 4'd12, 4'd8, 4'd0};

  function automatic logic [3:0] quant(
    input logic [7:0] c,
    input logic [3:0] off
  );
    logic [8:0] s;
    s = {1'b0, c} + {5'd0, off};
    quant = s[8] ? 4'hF : s[7:4];
  endfunction

endpackage

// File: rtl/frame_dispatcher_if.sv
// Raymarcher request/result and frame buffer write bundle.
// master = dispatcher side, slave = raymarcher / frame buffer side.
interface frame_dispatcher_if #(
  parameter int COORD_W = 33,
  parameter int ADDR_W  = 17
);

  logic [COORD_W-1:0] curr_x;
  logic [COORD_W-1:0] curr_y;
  logic               pixel_done;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [7:0]         red_in;
  logic [7:0]         green_in;
  logic [7:0]         blue_in;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [frame_pkg::FB_DATA_W-1:0] fb_data;

  modport master (
    output curr_x, curr_y,
    output fb_we, fb_addr, fb_data,
    input  pixel_done, out_x, out_y,
    input  red_in, green_in, blue_in
  );

  modport slave (
    input  curr_x, curr_y,
    input  fb_we, fb_addr, fb_data,
    output pixel_done, out_x, out_y,
    output red_in, green_in, blue_in
  );

endinterface

// File: rtl/rgb_quantiser.sv
// Reduces 8-bit RGB to 4:4:4 and registers it on load_i.
// RGB_DITHER_EN adds the Bayer offset with saturation first.
module rgb_quantiser
  import frame_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 load_i,
  input  logic                 x0_i,
  input  logic                 y0_i,
  input  logic [7:0]           r_i,
  input  logic [7:0]           g_i,
  input  logic [7:0]           b_i,
  output logic [FB_DATA_W-1:0] data_o
);

  logic [3:0]           off;
  logic [FB_DATA_W-1:0] data_d;
  logic [FB_DATA_W-1:0] data_q;

`ifdef RGB_DITHER_EN
  assign off = BAYER2X2[y0_i][x0_i];
`else
  logic unused_xy;
  assign unused_xy = x0_i ^ y0_i;
  assign off = 4'd0;
`endif

  assign data_d = {
    quant(r_i, off),
    quant(g_i, off),
    quant(b_i, off)
  };

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/frame_dispatcher.sv
// Raster-order pixel dispatcher: one request in flight, writes
// quantised results to the frame buffer (RGB_DITHER_EN: dither).
module frame_dispatcher
  import frame_pkg::*;
#(
  parameter int WIDTH   = 300,
  parameter int HEIGHT  = 300,
  parameter int COORD_W = 33,
  parameter int ADDR_W  = 17
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  frame_dispatcher_if.master  bus,
  output logic                busy_out,
  output logic                frame_done,
  output logic [15:0]         mismatch_cnt
);

  localparam logic [COORD_W-1:0] X_LAST =
    COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST =
    COORD_W'(HEIGHT - 1);

  dispatch_state_t    state_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               we_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        mcnt_q;

  logic hit;
  logic last;
  logic load;

  assign hit  = bus.pixel_done
             && (bus.out_x == x_q)
             && (bus.out_y == y_q);
  assign load = (state_q == WAIT) && hit;
  assign last = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q <= WAIT;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            mcnt_q  <= '0;
          end
        end
        WAIT: begin
          if (hit) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
          end else if (bus.pixel_done
                       && mcnt_q != 16'hFFFF) begin
            mcnt_q <= mcnt_q + 16'd1;
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= WAIT;
            addr_q  <= addr_q + ADDR_W'(1);
            // Raster advance: wrap x at end of line.
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + COORD_W'(1);
            end else begin
              x_q <= x_q + COORD_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  rgb_quantiser u_quant (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load_i (load),
    .x0_i   (x_q[0]),
    .y0_i   (y_q[0]),
    .r_i    (bus.red_in),
    .g_i    (bus.green_in),
    .b_i    (bus.blue_in),
    .data_o (bus.fb_data)
  );

  assign bus.curr_x  = x_q;
  assign bus.curr_y  = y_q;
  assign bus.fb_we   = we_q;
  assign bus.fb_addr = addr_q;
  assign busy_out     = busy_q;
  assign frame_done   = done_q;
  assign mismatch_cnt = mcnt_q;

endmodule
